// File: rtl/fifo_ecc_pkg.sv
// fifo_ecc_pkg: shared Hamming(12,8) definitions for the ECC FIFO.
// The write-side encoder and the read-side drain both use this package.
// Lane layout: bit index p-1 holds Hamming position p.
// Parity bits sit at positions 1, 2, 4 and 8.
package fifo_ecc_pkg;

  localparam int unsigned LANE_W = 12;
  localparam int unsigned CHK_W  = 4;

  typedef logic [CHK_W-1:0] syndrome_t;

  // Hamming positions of data bits d0..d7
  localparam logic [3:0] DATA_POS [8] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};

  // XOR of the positions of all set bits; zero for a clean code word
  function automatic syndrome_t ecc_syndrome(input logic [LANE_W-1:0] c);
    syndrome_t s;
    s = '0;
    for (int unsigned p = 1; p <= LANE_W; p++) begin
      if (c[p-1]) s = s ^ syndrome_t'(p);
    end
    return s;
  endfunction

  // Place the data bits, then choose parity so that the syndrome becomes zero
  function automatic logic [LANE_W-1:0] ecc_encode(input logic [7:0] d);
    logic [LANE_W-1:0] c;
    syndrome_t         s;
    c = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      c[DATA_POS[k] - 4'd1] = d[k];
    end
    s = ecc_syndrome(c);
    for (int unsigned j = 0; j < CHK_W; j++) begin
      c[(1 << j) - 1] = s[j];
    end
    return c;
  endfunction

  // Pull d0..d7 back out of a code word
  function automatic logic [7:0] ecc_extract(input logic [LANE_W-1:0] c);
    logic [7:0] d;
    for (int unsigned k = 0; k < 8; k++) begin
      d[k] = c[DATA_POS[k] - 4'd1];
    end
    return d;
  endfunction

endpackage

// File: rtl/fifo_ecc_drain_if.sv
// fifo_ecc_drain_if: corrected-data output stream of the drain stage.
// It carries the valid/ready handshake, the data and the per-word ECC flags.
interface fifo_ecc_drain_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_corrected;
  logic                  out_uncorr;

  modport master (
    output out_valid,
    output out_data,
    output out_corrected,
    output out_uncorr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_corrected,
    input  out_uncorr,
    output out_ready
  );
endinterface

// File: rtl/ecc_lane_dec.sv
// ecc_lane_dec: combinational Hamming(12,8) decoder for one byte lane.
// It corrects single-bit errors.
// Syndromes 13..15 flag the lane as uncorrectable and pass the data through raw.
module ecc_lane_dec
  import fifo_ecc_pkg::*;
(
  input  logic [LANE_W-1:0] i_code,
  output logic [7:0]        o_data,
  output logic              o_corrected,
  output logic              o_uncorr
);

  syndrome_t         w_syn;
  logic [LANE_W-1:0] w_fix;

  // Compute the syndrome, flip the indicated position, and extract the data
  always_comb begin
    w_syn       = ecc_syndrome(i_code);
    w_fix       = i_code;
    o_corrected = 1'b0;
    o_uncorr    = 1'b0;
    if (w_syn > syndrome_t'(LANE_W)) begin
      o_uncorr = 1'b1;
    end else if (w_syn != '0) begin
      w_fix[w_syn - 4'd1] = ~w_fix[w_syn - 4'd1];
      o_corrected         = 1'b1;
    end
    o_data = ecc_extract(w_fix);
  end

endmodule

// File: rtl/fifo_ecc_drain.sv
// fifo_ecc_drain: drain stage on the read side of the ECC FIFO.
// It pops encoded words and decodes each byte lane.
// Results pass through a 2-entry output buffer onto a valid/ready stream.
// Optional feature: define FIFO_DRAIN_ERR_CNT_EN to add saturating
// corrected/uncorrectable counters with a synchronous clear.
module fifo_ecc_drain
  import fifo_ecc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
`ifdef FIFO_DRAIN_ERR_CNT_EN
  parameter int unsigned CNT_WIDTH  = 16,
`endif
  localparam int unsigned ENC_WIDTH = DATA_WIDTH + DATA_WIDTH / 8 * CHK_W
) (
  input  logic                  Clock,
  input  logic                  Reset_,
  input  logic                  Empty_,
  input  logic                  HalfFull_,
  input  logic [ENC_WIDTH-1:0]  DataOutEnc,
  output logic                  ReadEn,
`ifdef FIFO_DRAIN_ERR_CNT_EN
  input  logic                  err_cnt_clr,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt,
`endif
  fifo_ecc_drain_if.master      out_if
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] w_dec_data;
  logic [LANES-1:0]      w_lane_corr;
  logic [LANES-1:0]      w_lane_unc;
  logic                  w_corr;
  logic                  w_unc;
  logic                  w_pop;
  logic [1:0]            w_occ;
  logic [2:0]            w_load;

  logic                  r_infl;
  logic                  r_head_vld;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic                  r_head_corr;
  logic                  r_head_unc;
  logic                  r_tail_vld;
  logic [DATA_WIDTH-1:0] r_tail_data;
  logic                  r_tail_corr;
  logic                  r_tail_unc;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ecc_lane_dec u_dec (
      .i_code      (DataOutEnc[k*LANE_W +: LANE_W]),
      .o_data      (w_dec_data[k*8 +: 8]),
      .o_corrected (w_lane_corr[k]),
      .o_uncorr    (w_lane_unc[k])
    );
  end

  // Word flags are the OR over all lanes
  always_comb begin
    w_corr = |w_lane_corr;
    w_unc  = |w_lane_unc;
  end

  // Credit check: buffered words + reads in flight must leave room.
  // A pop in the same cycle frees its slot, which sustains 1 word/cycle.
  // Reset gates ReadEn directly so that it drops without waiting for a clock.
  always_comb begin
    w_occ  = {1'b0, r_head_vld} + {1'b0, r_tail_vld};
    w_pop  = r_head_vld & out_if.out_ready;
    w_load = {1'b0, w_occ} - {2'b00, w_pop} + {2'b00, r_infl};
    ReadEn = Reset_ & Empty_ & (w_load < 3'd2) & (~r_infl | ~HalfFull_);
  end

  // A read issued this cycle returns data on the next cycle
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) r_infl <= 1'b0;
    else         r_infl <= ReadEn;
  end

  // Two-entry output buffer. The head drives the outputs; the tail holds the
  // second word. Arriving data goes to the head when it is free or being
  // vacated with an empty tail, otherwise to the tail.
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      r_head_vld  <= 1'b0;
      r_head_data <= '0;
      r_head_corr <= 1'b0;
      r_head_unc  <= 1'b0;
      r_tail_vld  <= 1'b0;
      r_tail_data <= '0;
      r_tail_corr <= 1'b0;
      r_tail_unc  <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_vld) begin
        r_head_data <= r_tail_data;
        r_head_corr <= r_tail_corr;
        r_head_unc  <= r_tail_unc;
        if (r_infl) begin
          r_tail_data <= w_dec_data;
          r_tail_corr <= w_corr;
          r_tail_unc  <= w_unc;
        end else begin
          r_tail_vld  <= 1'b0;
        end
      end else if (r_infl) begin
        r_head_data <= w_dec_data;
        r_head_corr <= w_corr;
        r_head_unc  <= w_unc;
      end else begin
        r_head_vld  <= 1'b0;
      end
    end else if (r_infl) begin
      if (!r_head_vld) begin
        r_head_vld  <= 1'b1;
        r_head_data <= w_dec_data;
        r_head_corr <= w_corr;
        r_head_unc  <= w_unc;
      end else begin
        r_tail_vld  <= 1'b1;
        r_tail_data <= w_dec_data;
        r_tail_corr <= w_corr;
        r_tail_unc  <= w_unc;
      end
    end
  end

  // Output stream is the buffer head
  always_comb begin
    out_if.out_valid     = r_head_vld;
    out_if.out_data      = r_head_data;
    out_if.out_corrected = r_head_corr;
    out_if.out_uncorr    = r_head_unc;
  end

`ifdef FIFO_DRAIN_ERR_CNT_EN
  // Saturating event counters on accepted words; uncorrectable outranks corrected
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (err_cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (w_pop) begin
      if (r_head_unc) begin
        if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
      end else if (r_head_corr) begin
        if (corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ecc_drain.sv
// tb_fifo_ecc_drain: directed self-checking bench for fifo_ecc_drain.
// A small FIFO model answers ReadEn with one cycle of read latency.
// The model can make Empty_ lag by one cycle.
module tb_fifo_ecc_drain;

  logic        Clock = 1'b0;
  logic        Reset_;
  logic        Empty_;
  logic        HalfFull_;
  logic [47:0] DataOutEnc;
  logic        ReadEn;
`ifdef FIFO_DRAIN_ERR_CNT_EN
  logic        err_cnt_clr;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
`endif

  fifo_ecc_drain_if #(.DATA_WIDTH(32)) out_if ();

  fifo_ecc_drain #(
    .DATA_WIDTH (32)
  ) dut (
    .Clock      (Clock),
    .Reset_     (Reset_),
    .Empty_     (Empty_),
    .HalfFull_  (HalfFull_),
    .DataOutEnc (DataOutEnc),
    .ReadEn     (ReadEn),
`ifdef FIFO_DRAIN_ERR_CNT_EN
    .err_cnt_clr(err_cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt),
`endif
    .out_if     (out_if.master)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent Hamming(12,8) encoder: {d7,d6,d5,d4,p8,d3,d2,d1,p4,d0,p2,p1}
  function automatic logic [11:0] tb_enc_lane(input logic [7:0] d);
    logic p1, p2, p4, p8;
    p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
    p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {d[7], d[6], d[5], d[4], p8, d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  function automatic logic [47:0] tb_enc_word(input logic [31:0] w);
    return {tb_enc_lane(w[31:24]), tb_enc_lane(w[23:16]), tb_enc_lane(w[15:8]), tb_enc_lane(w[7:0])};
  endfunction

  // FIFO model
  logic [47:0] fq[$];
  logic        rd_q       = 1'b0;
  logic        lag_empty  = 1'b0;
  logic        empty_prev = 1'b0;
  logic        empty_now;
  int          underflow  = 0;

  always @(negedge Clock) rd_q = ReadEn;

  always @(posedge Clock) begin
    #2;
    if (rd_q) begin
      if (fq.size() != 0) DataOutEnc = fq.pop_front();
      else                underflow++;
    end
    empty_now  = (fq.size() != 0);
    Empty_     = lag_empty ? empty_prev : empty_now;
    empty_prev = empty_now;
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Wait (bounded) for a valid word and check it; out_ready must already be 1
  task automatic expect_word(input string tag, input logic [31:0] d, input logic c,
                             input logic u, output int lat);
    lat = 0;
    @(negedge Clock);
    while (!out_if.out_valid && lat < 20) begin
      lat++;
      @(negedge Clock);
    end
    check_eq({tag, ".valid"}, out_if.out_valid, 1'b1);
    check_eq({tag, ".data"},  out_if.out_data, d);
    check_eq({tag, ".corr"},  out_if.out_corrected, c);
    check_eq({tag, ".unc"},   out_if.out_uncorr, u);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  logic [31:0] clean_w [4] = '{32'h00000000, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF};
  logic [31:0] bp_w    [5] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'h3C3C3C3C, 32'h00FF00FF, 32'hCAFEF00D};

  initial begin
    int          lat;
    int          n_re;
    int          n_v;
    logic [31:0] got;

    Reset_     = 1'b0;
    Empty_     = 1'b0;
    HalfFull_  = 1'b1;
    DataOutEnc = '0;
    out_if.out_ready = 1'b0;
`ifdef FIFO_DRAIN_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif

    // Reset state
    @(posedge Clock);
    @(negedge Clock);
    Empty_ = 1'b1;
    #1;
    check_eq("rst.readen", ReadEn, 1'b0);
    check_eq("rst.valid",  out_if.out_valid, 1'b0);
    check_eq("rst.data",   out_if.out_data, 32'h0);
    check_eq("rst.corr",   out_if.out_corrected, 1'b0);
    check_eq("rst.unc",    out_if.out_uncorr, 1'b0);
`ifdef FIFO_DRAIN_ERR_CNT_EN
    check_eq("rst.ccnt", corr_cnt, 16'd0);
    check_eq("rst.ucnt", uncorr_cnt, 16'd0);
`endif
    Empty_ = 1'b0;
    step();
    Reset_ = 1'b1;
    step();

    // Clean stream: 4 back-to-back reads, outputs from cycle 2
    for (int i = 0; i < 4; i++) fq.push_back(tb_enc_word(clean_w[i]));
    HalfFull_ = 1'b0;
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clock);
      check_eq($sformatf("clean.re%0d", i), ReadEn, (i < 4));
      check_eq($sformatf("clean.v%0d", i), out_if.out_valid, (i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) begin
        check_eq($sformatf("clean.d%0d", i), out_if.out_data, clean_w[i-2]);
        check_eq($sformatf("clean.c%0d", i), out_if.out_corrected, 1'b0);
        check_eq($sformatf("clean.u%0d", i), out_if.out_uncorr, 1'b0);
      end
    end
    step();

    // Single-bit error: lane 0 position 5
    fq.push_back(tb_enc_word(32'hDEADBEEF) ^ 48'h10);
    expect_word("sbe", 32'hDEADBEEF, 1'b1, 1'b0, lat);
    check_eq("sbe.latency", lat, 2);
    @(negedge Clock);
`ifdef FIFO_DRAIN_ERR_CNT_EN
    check_eq("sbe.ccnt", corr_cnt, 16'd1);
    check_eq("sbe.ucnt", uncorr_cnt, 16'd0);
`endif
    step();

    // Uncorrectable: lane 1 positions 1 and 12 (syndrome 13)
    fq.push_back(tb_enc_word(32'h12345678) ^ 48'h801000);
    expect_word("unc", 32'h1234D678, 1'b0, 1'b1, lat);
    @(negedge Clock);
`ifdef FIFO_DRAIN_ERR_CNT_EN
    check_eq("unc.ccnt", corr_cnt, 16'd1);
    check_eq("unc.ucnt", uncorr_cnt, 16'd1);
`endif
    step();

    // Backpressure: 5 words queued, consumer stalled for 10 cycles
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fq.push_back(tb_enc_word(bp_w[i]) ^ ((i == 1) ? 48'h800000000000 : 48'h0));
    n_re = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (ReadEn) n_re++;
      if (i >= 2) check_eq($sformatf("bp.hold%0d", i), out_if.out_data, bp_w[0]);
    end
    check_eq("bp.pops", n_re, 2);
    check_eq("bp.valid", out_if.out_valid, 1'b1);
    step();
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_word($sformatf("bp.w%0d", i), bp_w[i], (i == 1), 1'b0, lat);
    end
    @(negedge Clock);
`ifdef FIFO_DRAIN_ERR_CNT_EN
    check_eq("bp.ccnt", corr_cnt, 16'd2);
    step();
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    @(negedge Clock);
    check_eq("clr.ccnt", corr_cnt, 16'd0);
    check_eq("clr.ucnt", uncorr_cnt, 16'd0);
`endif
    step();

    // Flag lag: Empty_ trails the pop by one cycle and HalfFull_ stays high
    lag_empty = 1'b1;
    HalfFull_ = 1'b1;
    step();
    fq.push_back(tb_enc_word(32'h5A5A1234));
    n_re = 0;
    n_v  = 0;
    got  = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      if (ReadEn) n_re++;
      if (out_if.out_valid) begin
        n_v++;
        got = out_if.out_data;
      end
    end
    check_eq("lag.pops", n_re, 1);
    check_eq("lag.underflow", underflow, 0);
    check_eq("lag.words", n_v, 1);
    check_eq("lag.data", got, 32'h5A5A1234);
    check_eq("lag.empty", Empty_, 1'b0);
    step();
    lag_empty = 1'b0;
    HalfFull_ = 1'b0;
    step();

    // Reset with two buffered words and a pending read
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) fq.push_back(tb_enc_word(32'h77770000 + i));
    for (int i = 0; i < 4; i++) @(negedge Clock);
    step();
    out_if.out_ready = 1'b1;
    @(negedge Clock);
    check_eq("rst2.pre_valid", out_if.out_valid, 1'b1);
    check_eq("rst2.pre_re", ReadEn, 1'b1);
    #1;
    Reset_ = 1'b0;
    fq.delete();
    rd_q = 1'b0;
    #1;
    check_eq("rst2.re", ReadEn, 1'b0);
    check_eq("rst2.valid", out_if.out_valid, 1'b0);
    check_eq("rst2.data", out_if.out_data, 32'h0);
    step();
    step();
    Reset_ = 1'b1;
    n_re = 0;
    n_v  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (ReadEn) n_re++;
      if (out_if.out_valid) n_v++;
    end
    check_eq("rst2.stale_words", n_v, 0);
    check_eq("rst2.stale_reads", n_re, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
